// File: rtl/execute_stage.sv
// Execute stage: ALU, load/store address generation and an iterative 32-cycle
// shift-add multiplier, all registered into the EX/MEM boundary.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ID_valid,
  input  logic        ID_wr_en,
  input  logic        ID_mem_en,
  input  logic        ID_mem_wr,
  input  logic [2:0]  ID_fn_3,
  input  logic [4:0]  ID_rd_sel,
  input  logic [6:0]  ID_opcode,
  input  logic [6:0]  ID_fn_7,
  input  logic [31:0] ID_rs1_val,
  input  logic [31:0] ID_mux_val,
  input  logic [31:0] ID_rs2_val,
  output logic        stall,
  output logic        EX_valid,
  output logic        EX_wr_en,
  output logic        EX_mem_en,
  output logic        EX_mem_wr,
  output logic [2:0]  EX_fn_3,
  output logic [4:0]  EX_rd_sel,
  output logic [31:0] EX_alu_out,
  output logic [31:0] EX_store_val
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_neg;

  logic        w_is_r;
  logic        w_is_m;
  logic        w_mul_req;
  logic        w_a_signed;
  logic        w_b_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_prod;
  logic [31:0] w_prod_word;
  logic [31:0] w_alu;
  logic [31:0] w_result;

  assign w_is_r    = (ID_opcode == OP_R);
  assign w_is_m    = w_is_r && (ID_fn_7 == 7'b0000001);
  assign w_mul_req = ID_valid && w_is_m && !ID_fn_3[2];

  // MULH treats both operands as signed, MULHSU only A; MUL and MULHU are unsigned.
  assign w_a_signed = (ID_fn_3[1:0] == 2'b01) || (ID_fn_3[1:0] == 2'b10);
  assign w_b_signed = (ID_fn_3[1:0] == 2'b01);
  assign w_abs_a    = (w_a_signed && ID_rs1_val[31]) ? -ID_rs1_val : ID_rs1_val;
  assign w_abs_b    = (w_b_signed && ID_mux_val[31]) ? -ID_mux_val : ID_mux_val;

  assign w_prod      = r_neg ? -r_acc : r_acc;
  assign w_prod_word = (ID_fn_3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

  assign stall = ((r_state == S_IDLE) && w_mul_req) || (r_state == S_MUL);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_req) w_state_next = S_MUL;
      S_MUL:   if (r_cnt == 5'd31) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_mul_req && !flush) begin
        r_mcand  <= {32'b0, w_abs_a};
        r_mplier <= w_abs_b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_neg    <= (w_a_signed & ID_rs1_val[31]) ^ (w_b_signed & ID_mux_val[31]);
      end else if (r_state == S_MUL) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 5'd1;
      end
    end
  end

  always_comb begin
    w_alu = '0;
    case (ID_fn_3)
      3'b000: w_alu = (w_is_r && ID_fn_7 == 7'b0100000) ? ID_rs1_val - ID_mux_val
                                                          : ID_rs1_val + ID_mux_val;
      3'b001: w_alu = ID_rs1_val << ID_mux_val[4:0];
      3'b010: w_alu = {31'b0, $signed(ID_rs1_val) < $signed(ID_mux_val)};
      3'b011: w_alu = {31'b0, ID_rs1_val < ID_mux_val};
      3'b100: w_alu = ID_rs1_val ^ ID_mux_val;
      3'b101: w_alu = ID_fn_7[5] ? $unsigned($signed(ID_rs1_val) >>> ID_mux_val[4:0])
                                 : ID_rs1_val >> ID_mux_val[4:0];
      3'b110: w_alu = ID_rs1_val | ID_mux_val;
      3'b111: w_alu = ID_rs1_val & ID_mux_val;
      default: w_alu = '0;
    endcase
  end

  // Multiply results are only ever captured in DONE, since stall blocks earlier capture.
  always_comb begin
    w_result = '0;
    case (ID_opcode)
      OP_R:               w_result = w_is_m ? (ID_fn_3[2] ? 32'b0 : w_prod_word) : w_alu;
      OP_I:               w_result = w_alu;
      OP_LOAD, OP_STORE:  w_result = ID_rs1_val + ID_mux_val;
      OP_LUI:             w_result = ID_mux_val;
      OP_AUIPC:           w_result = ID_rs1_val + ID_mux_val;
      default:            w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      EX_valid     <= 1'b0;
      EX_wr_en     <= 1'b0;
      EX_mem_en    <= 1'b0;
      EX_mem_wr    <= 1'b0;
      EX_fn_3      <= '0;
      EX_rd_sel    <= '0;
      EX_alu_out   <= '0;
      EX_store_val <= '0;
    end else if (flush || stall || !ID_valid) begin
      EX_valid  <= 1'b0;
      EX_wr_en  <= 1'b0;
      EX_mem_en <= 1'b0;
      EX_mem_wr <= 1'b0;
    end else begin
      EX_valid     <= 1'b1;
      EX_wr_en     <= ID_wr_en;
      EX_mem_en    <= ID_mem_en;
      EX_mem_wr    <= ID_mem_wr;
      EX_fn_3      <= ID_fn_3;
      EX_rd_sel    <= ID_rd_sel;
      EX_alu_out   <= w_result;
      EX_store_val <= ID_rs2_val;
    end
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RV32I CPU, sitting directly downstream of the decode pipeline register and consuming its ID_* outputs. It computes ALU results, load/store effective addresses and RV32M multiplies, then registers everything into the EX/MEM boundary. Multiplies run on an iterative 32-cycle shift-add unit; the stage raises `stall` so the upstream registers hold the instruction until the product is ready.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  kill the instruction in ID and abort any multiply
- `ID_valid`  in  1  ID stage holds a real instruction
- `ID_wr_en`, `ID_mem_en`, `ID_mem_wr`  in  1 each  register-write / memory-enable / memory-write controls
- `ID_fn_3`  in  3  funct3
- `ID_rd_sel`  in  5  destination register
- `ID_opcode`, `ID_fn_7`  in  7 each  opcode, funct7
- `ID_rs1_val`  in  32  operand A
- `ID_mux_val`  in  32  operand B (rs2 or immediate)
- `ID_rs2_val`  in  32  raw rs2, used as store data
- `stall`  out  1  hold ID registers and PC this cycle
- `EX_valid`, `EX_wr_en`, `EX_mem_en`, `EX_mem_wr`  out  1 each  registered controls
- `EX_fn_3`  out  3  passed through for memory access width
- `EX_rd_sel`  out  5  passed through
- `EX_alu_out`  out  32  result or effective address
- `EX_store_val`  out  32  registered `ID_rs2_val`

## Operation
- **Result by opcode:**
  - 0110011 (R) and 0010011 (I-ALU): ALU on A = `ID_rs1_val`, B = `ID_mux_val`.
  - 0000011 / 0100011 (load/store): A+B.
  - 0110111 (LUI): B.
  - 0010111 (AUIPC): A+B (decode supplies PC as A).
  - Any other opcode: result 0.
- **ALU by fn_3:**
  - 000: ADD; SUB only when R-type and fn_7 = 0100000.
  - 001: SLL by B[4:0].
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when fn_7[5] = 1.
  - 110: OR.
  - 111: AND.
- **Arithmetic:** all results are 32-bit and wrap modulo 2^32. SLT/SLTU yield 0 or 1.
- **Multiply request:** an instruction with R-type, fn_7 = 0000001 and fn_3[2] = 0 is a mul request when `ID_valid` = 1.
  - fn_3 000: MUL, low 32 bits.
  - fn_3 001: MULH, signed×signed, high 32 bits.
  - fn_3 010: MULHSU, signed×unsigned, high 32 bits.
  - fn_3 011: MULHU, unsigned×unsigned, high 32 bits.
- **Division:** fn_7 = 0000001 with fn_3[2] = 1 is unsupported and produces result 0 in a single cycle.
- **Multiplier FSM states:** IDLE, MUL, DONE.
  - IDLE → MUL on a mul request. Captures |A| and |B| per signedness, the sign flag (sign_A XOR sign_B, each only if that operand is signed), and clears the 64-bit accumulator and 5-bit counter.
  - MUL: one shift-add step per cycle; counter counts 0..31. Exits to DONE after count 31.
  - DONE: result = accumulator, two's-complement negated over 64 bits if the sign flag is set. Selects low or high word per fn_3. Always returns to IDLE next cycle.
- **stall** = (IDLE and mul request) or (state == MUL). Combinational; low in DONE.
- **EX register update each edge:**
  - `rst`: all EX outputs 0, FSM IDLE.
  - Else `flush`: EX_valid/wr_en/mem_en/mem_wr ← 0; FSM ← IDLE. Data fields are don't-care.
  - Else `stall`: insert a bubble (EX_valid and all three controls ← 0).
  - Else `ID_valid` = 0: bubble.
  - Else: load all EX fields from the ID inputs and the computed result.
- Priority: `rst` > `flush` > `stall` > normal.

## Timing
- **Reset:** all outputs 0 (including `stall` once the FSM is IDLE). The reset takes effect at the first rising edge with `rst` high.
- **Non-mul instructions:** 1-cycle latency. ID value at edge N appears on EX_* after edge N+1.
- **Multiply:** ID holds the instruction from cycle 0.
  - `stall` is high cycles 0–32 (33 cycles).
  - Cycle 33 is DONE: `stall` is low, and EX captures the product at the end of cycle 33.
  - Total 34 cycles of occupancy.
- A new mul request in the cycle right after DONE starts a fresh operation. There is no back-to-back reuse of the old product.
- A `flush` or `rst` asserted mid-multiply aborts it. `stall` drops in the next cycle, and no result is ever written.
- Upstream registers must hold while `stall` = 1. The stage samples operands only in IDLE.

## Test plan
- After reset: ADD 0x7FFFFFFF + 0x00000001 → EX_alu_out = 0x80000000 one cycle later; SUB (fn_7 = 0100000) 0 − 1 → 0xFFFFFFFF.
- SRA 0x80000000 by 4 → 0xF8000000; SRL → 0x08000000; SLT 0xFFFFFFFF vs 1 → 1; SLTU → 0.
- Store with rs1 = 0x1000, imm = 0x0FFC, rs2 = 0xDEADBEEF → EX_alu_out = 0x1FFC, EX_store_val = 0xDEADBEEF, EX_mem_en = EX_mem_wr = 1.
- MUL 3 × 0xFFFFFFFB → `stall` high exactly 33 cycles, EX_valid bubbles meanwhile, then EX_alu_out = 0xFFFFFFF1 with EX_valid = 1.
- 0xFFFFFFFF × 0xFFFFFFFF: MULH → 0x00000000, MULHU → 0xFFFFFFFE, MULHSU → 0xFFFFFFFF.
- `flush` at cycle 10 of a multiply → FSM IDLE, `stall` = 0 next cycle, EX_valid stays 0. Repeat with `rst` at cycle 20 → all outputs 0.
